// File: rtl/knn_pkg.sv
// Shared types and helpers for the KNN stream controller.
// The optional stall counter is enabled with the KNN_CTRL_PERF_EN macro.
package knn_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_TEST = 3'd1,
        STREAM    = 3'd2,
        WAIT_RES  = 3'd3,
        CAPTURE   = 3'd4,
        OUTPUT    = 3'd5
    } knn_ctrl_state_t;

    // One stream beat carries one dimension, so a vector takes DIMS beats.
    function automatic int unsigned beats_per_vector(input int unsigned dims);
        return dims;
    endfunction

    function automatic logic [63:0] groups_needed(input logic [63:0] num_train,
                                                  input int unsigned knns);
        return (num_train + 64'(knns) - 64'd1) / 64'(knns);
    endfunction

    function automatic int unsigned ptr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/knn_result_buf.sv
// K-entry result capture RAM: fills from the array burst, then replays the
// words on a valid/ready stream, nearest first.
module knn_result_buf
    import knn_pkg::*;
#(
    parameter int K = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [WORD_W-1:0] wr_data_i,
    output logic              wr_last_o,
    input  logic              m_ready_i,
    output logic              m_valid_o,
    output logic [WORD_W-1:0] m_data_o,
    output logic              m_last_o,
    output logic              rd_done_o
);

    localparam int PW = ptr_w(K);
    localparam logic [PW-1:0] LAST_IDX = PW'(K - 1);

    logic [WORD_W-1:0] mem_q [K];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              valid_q, valid_d;
    logic              rd_fire;

    assign wr_last_o = wr_en_i && (wr_ptr_q == LAST_IDX);
    assign rd_fire   = valid_q && m_ready_i;
    assign m_valid_o = valid_q;
    assign m_last_o  = valid_q && (rd_ptr_q == LAST_IDX);
    assign rd_done_o = rd_fire && m_last_o;
    // Data is forced to zero whenever nothing is being offered.
    assign m_data_o  = valid_q ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        if (wr_en_i) begin
            wr_ptr_d = wr_last_o ? '0 : wr_ptr_q + PW'(1);
        end
        if (wr_last_o) begin
            valid_d = 1'b1;
        end
        if (rd_fire) begin
            rd_ptr_d = m_last_o ? '0 : rd_ptr_q + PW'(1);
        end
        if (rd_done_o) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/knn_stream_ctrl.sv
// KNN array sequencer: loads a test vector, streams train beats into the array
// and replays the K-word result burst. KNN_CTRL_PERF_EN adds perf_stall.
module knn_stream_ctrl
    import knn_pkg::*;
#(
    parameter int DIMS  = 8,
    parameter int KNNS  = 3,
    parameter int K     = 8,
    parameter int CNT_W = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [CNT_W-1:0]              num_train,
    output logic                          busy,
    output logic                          err,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [WORD_W*KNNS-1:0]        s_data,
    output logic                          arr_en,
    output logic [WORD_W*(KNNS+1)-1:0]    arr_datain,
    input  logic                          arr_done,
    input  logic [WORD_W-1:0]             arr_dataout,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [WORD_W-1:0]             m_data,
    output logic                          m_last,
`ifdef KNN_CTRL_PERF_EN
    output logic [31:0]                   perf_stall,
`endif
    output knn_ctrl_state_t               dbg_state
);

    localparam int BPV = beats_per_vector(DIMS);
    localparam int DW  = ptr_w(BPV);
    localparam logic [DW-1:0]  DIM_LAST = DW'(BPV - 1);
    localparam logic [CNT_W:0] KNNS_W   = (CNT_W + 1)'(KNNS);

    knn_ctrl_state_t               state_q;
    logic [DW-1:0]                 dim_cnt_q;
    logic [CNT_W-1:0]              num_q;
    logic [CNT_W-1:0]              sent_q;
    logic [WORD_W-1:0]             test_buf_q [BPV];
    logic                          busy_q, err_q, s_ready_q, arr_en_q;
    logic [WORD_W*(KNNS+1)-1:0]    arr_datain_q;

    logic                          s_fire;
    logic                          dim_wrap;
    logic [CNT_W:0]                sent_sum;
    logic                          res_wr_en, res_wr_last, res_rd_done;

    // Both streams transfer a beat only on a cycle where valid and ready are
    // high together; valid never waits on ready and data holds until taken.
    assign s_fire    = s_ready_q && s_valid;
    assign dim_wrap  = (dim_cnt_q == DIM_LAST);
    assign sent_sum  = {1'b0, sent_q} + KNNS_W;
    assign res_wr_en = ((state_q == WAIT_RES) && arr_done) || (state_q == CAPTURE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            dim_cnt_q    <= '0;
            num_q        <= '0;
            sent_q       <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            s_ready_q    <= 1'b0;
            arr_en_q     <= 1'b0;
            arr_datain_q <= '0;
        end else begin
            err_q    <= 1'b0;
            arr_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (num_train == '0) begin
                            err_q <= 1'b1;
                        end else begin
                            num_q     <= num_train;
                            sent_q    <= '0;
                            dim_cnt_q <= '0;
                            busy_q    <= 1'b1;
                            s_ready_q <= 1'b1;
                            state_q   <= LOAD_TEST;
                        end
                    end
                end
                LOAD_TEST: begin
                    if (s_fire) begin
                        dim_cnt_q <= dim_wrap ? '0 : dim_cnt_q + DW'(1);
                        if (dim_wrap) begin
                            state_q <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (s_fire) begin
                        arr_en_q     <= 1'b1;
                        arr_datain_q <= {test_buf_q[dim_cnt_q], s_data};
                        dim_cnt_q    <= dim_wrap ? '0 : dim_cnt_q + DW'(1);
                        if (dim_wrap) begin
                            // Compare on the unsaturated sum so a huge set still terminates.
                            sent_q <= sent_sum[CNT_W] ? '1 : sent_sum[CNT_W-1:0];
                            if (sent_sum >= {1'b0, num_q}) begin
                                s_ready_q <= 1'b0;
                                state_q   <= WAIT_RES;
                            end
                        end
                    end
                end
                WAIT_RES: begin
                    if (arr_done) begin
                        state_q <= res_wr_last ? OUTPUT : CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (res_wr_last) begin
                        state_q <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (res_rd_done) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((state_q == LOAD_TEST) && s_fire) begin
            test_buf_q[dim_cnt_q] <= s_data[WORD_W-1:0];
        end
    end

`ifdef KNN_CTRL_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if ((state_q == IDLE) && start && (num_train != '0)) begin
            perf_q <= '0;
        end else if ((state_q == STREAM) && !s_valid && (perf_q != '1)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall = perf_q;
`endif

    knn_result_buf #(
        .K(K)
    ) u_result_buf (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (res_wr_en),
        .wr_data_i (arr_dataout),
        .wr_last_o (res_wr_last),
        .m_ready_i (m_ready),
        .m_valid_o (m_valid),
        .m_data_o  (m_data),
        .m_last_o  (m_last),
        .rd_done_o (res_rd_done)
    );

    assign busy       = busy_q;
    assign err        = err_q;
    assign s_ready    = s_ready_q;
    assign arr_en     = arr_en_q;
    assign arr_datain = arr_datain_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_knn_stream_ctrl.sv
// Randomized scoreboard bench for knn_stream_ctrl; the perf_stall checks are
// compiled in when KNN_CTRL_PERF_EN is defined.
`timescale 1ns/1ps
module tb_knn_stream_ctrl;
    import knn_pkg::*;

    localparam int DIMS   = 8;
    localparam int KNNS   = 3;
    localparam int K      = 8;
    localparam int CNT_W  = 32;
    localparam int SW     = WORD_W * KNNS;
    localparam int AW     = WORD_W * (KNNS + 1);
    localparam int BUDGET = 3000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_train = '0;
    logic             busy, err;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [SW-1:0]    s_data = '0;
    logic             arr_en;
    logic [AW-1:0]    arr_datain;
    logic             arr_done = 1'b0;
    logic [31:0]      arr_dataout = '0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [31:0]      m_data;
    logic             m_last;
    knn_ctrl_state_t  dbg_state;
`ifdef KNN_CTRL_PERF_EN
    logic [31:0]      perf_stall;
`endif

    knn_stream_ctrl #(.DIMS(DIMS), .KNNS(KNNS), .K(K), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_train   (num_train),
        .busy        (busy),
        .err         (err),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .arr_en      (arr_en),
        .arr_datain  (arr_datain),
        .arr_done    (arr_done),
        .arr_dataout (arr_dataout),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
`ifdef KNN_CTRL_PERF_EN
        .perf_stall  (perf_stall),
`endif
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    longint unsigned cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- scoreboard state ----------------
    typedef struct {
        longint unsigned due;
        logic [AW-1:0]   word;
    } arr_exp_t;

    arr_exp_t    arr_exp_q[$];
    logic [32:0] res_exp_q[$];
    arr_exp_t    e_arr;
    logic [32:0] e_res;
    logic [AW-1:0] last_word = '0;
    bit          reset_pending = 1'b1;
    int          n_vec = 0;
    int          n_miss = 0;
    int          ready_pct = 100;
    bit          hold_b3 = 1'b0;
    int          hold_n = 0;
    logic [31:0] test_dims [DIMS];

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name, input string what);
        n_vec++;
        n_miss++;
        $display("FAIL %s: %s (t=%0t)", name, what, $time);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset_pending) last_word = '0;
        if (arr_en === 1'b1) begin
            if (arr_exp_q.size() == 0) begin
                flag("arr_en", "got 1 expected 0 (no beat pending)");
            end else begin
                e_arr = arr_exp_q.pop_front();
                check("arr_latency", AW'(cyc), AW'(e_arr.due));
                check("arr_datain", arr_datain, e_arr.word);
                last_word = e_arr.word;
            end
        end else begin
            if (arr_exp_q.size() != 0) begin
                e_arr = arr_exp_q[0];
                if (e_arr.due <= cyc) begin
                    flag("arr_en", "got 0 expected 1 (beat due)");
                    void'(arr_exp_q.pop_front());
                end
            end
            check("arr_datain_held", arr_datain, last_word);
        end
        if (m_valid === 1'b1) begin
            if (res_exp_q.size() == 0) begin
                flag("m_valid", "got 1 expected 0 (no result pending)");
            end else begin
                e_res = res_exp_q[0];
                check("m_data", AW'(m_data), AW'(e_res[31:0]));
                check("m_last", AW'(m_last), AW'(e_res[32]));
                if (m_ready) void'(res_exp_q.pop_front());
            end
        end
        reset_pending = rst;
    end

    // ---------------- result sink ----------------
    always @(posedge clk) begin
        #1;
        if (hold_b3 && m_valid && (res_exp_q.size() == K - 3) && (hold_n < 5)) begin
            m_ready = 1'b0;
            hold_n++;
        end else begin
            m_ready = (int'($urandom_range(0, 99)) < ready_pct);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [SW-1:0] rand_sdata();
        logic [SW-1:0] r;
        for (int i = 0; i < KNNS; i++) r[i*WORD_W +: WORD_W] = $urandom;
        return r;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, AW'(busy), '0);
        check({tag, "_err"}, AW'(err), '0);
        check({tag, "_s_ready"}, AW'(s_ready), '0);
        check({tag, "_arr_en"}, AW'(arr_en), '0);
        check({tag, "_arr_datain"}, arr_datain, '0);
        check({tag, "_m_valid"}, AW'(m_valid), '0);
        check({tag, "_m_last"}, AW'(m_last), '0);
        check({tag, "_m_data"}, AW'(m_data), '0);
        check({tag, "_state"}, AW'(dbg_state), AW'(IDLE));
`ifdef KNN_CTRL_PERF_EN
        check({tag, "_perf_stall"}, AW'(perf_stall), '0);
`endif
    endtask

    task automatic run_query(input int num, input int vpct, input bit noise,
                             input bit fixed_res, input int abort_at);
        int            groups, total, b, budget, stall_cnt;
        bit            hs;
        logic [SW-1:0] d;
        logic [31:0]   w;
        arr_exp_t      ea;
        groups = (num + KNNS - 1) / KNNS;
        total  = DIMS + groups * DIMS;
        start = 1'b1;
        num_train = CNT_W'(num);
        tick();
        start = 1'b0;
        num_train = '0;
        @(negedge clk);
        check("busy_after_start", AW'(busy), AW'(1));
        check("err_on_good_start", AW'(err), '0);
`ifdef KNN_CTRL_PERF_EN
        check("perf_cleared_on_start", AW'(perf_stall), '0);
`endif
        tick();
        b = 0;
        budget = 0;
        stall_cnt = 0;
        while (b < total && budget < BUDGET) begin
            budget++;
            d = rand_sdata();
            s_data = d;
            s_valid = (int'($urandom_range(0, 99)) < vpct);
            if (b >= DIMS && !s_valid) stall_cnt++;
            if (noise) begin
                arr_done = ($urandom_range(0, 3) == 0);
                arr_dataout = $urandom;
                start = ($urandom_range(0, 7) == 0);
                num_train = CNT_W'($urandom_range(0, 20));
            end
            if (abort_at >= 0 && b == DIMS + abort_at) rst = 1'b1;
            @(negedge clk);
            #1;
            check("s_ready_load_stream", AW'(s_ready), AW'(1));
            check("err_quiet", AW'(err), '0);
            hs = s_valid && s_ready && !rst;
            if (hs) begin
                if (b < DIMS) begin
                    test_dims[b] = d[31:0];
                end else begin
                    ea.due  = cyc + 1;
                    ea.word = {test_dims[(b - DIMS) % DIMS], d};
                    arr_exp_q.push_back(ea);
                end
                b++;
            end
            tick();
            if (rst) begin
                rst = 1'b0;
                start = 1'b0;
                arr_done = 1'b0;
                s_valid = 1'b0;
                num_train = '0;
                @(negedge clk);
                check_idle("abort");
                tick();
                return;
            end
        end
        s_valid = 1'b0;
        start = 1'b0;
        arr_done = 1'b0;
        num_train = '0;
        if (b < total) flag("stream_budget", "train beats not all accepted");
        @(negedge clk);
        check("s_ready_wait_res", AW'(s_ready), '0);
        check("busy_wait_res", AW'(busy), AW'(1));
`ifdef KNN_CTRL_PERF_EN
        check("perf_stall", AW'(perf_stall), AW'(stall_cnt));
`endif
        tick();
        repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            check("m_valid_wait_res", AW'(m_valid), '0);
            tick();
        end
        for (int i = 0; i < K; i++) begin
            w = fixed_res ? 32'(10 + i) : $urandom;
            arr_done = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            arr_dataout = w;
            res_exp_q.push_back({(i == K - 1), w});
            @(negedge clk);
            check("m_valid_capture", AW'(m_valid), '0);
            tick();
        end
        arr_done = 1'b0;
        arr_dataout = $urandom;
        @(negedge clk);
        check("m_valid_latency", AW'(m_valid), AW'(1));
        #1;
        budget = 0;
        while (res_exp_q.size() != 0 && budget < BUDGET) begin
            budget++;
            if (noise) begin
                arr_done = 1'($urandom_range(0, 1));
                start = ($urandom_range(0, 3) == 0);
                num_train = CNT_W'($urandom_range(0, 20));
            end
            @(negedge clk);
            #1;
        end
        start = 1'b0;
        arr_done = 1'b0;
        num_train = '0;
        if (res_exp_q.size() != 0) begin
            flag("drain_budget", "result beats not all delivered");
            res_exp_q.delete();
        end
        @(negedge clk);
        check("busy_done", AW'(busy), '0);
        check("m_valid_done", AW'(m_valid), '0);
        check("state_done", AW'(dbg_state), AW'(IDLE));
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        tick();
        rst = 1'b0;
        tick();

        start = 1'b1;
        num_train = '0;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("err_pulse", AW'(err), AW'(1));
        check("err_busy", AW'(busy), '0);
        check("err_s_ready", AW'(s_ready), '0);
        check("err_state", AW'(dbg_state), AW'(IDLE));
        tick();
        @(negedge clk);
        check("err_clear", AW'(err), '0);
        check("err_s_ready2", AW'(s_ready), '0);
        tick();

        hold_b3 = 1'b1;
        hold_n = 0;
        ready_pct = 100;
        run_query(6, 100, 1'b0, 1'b1, -1);
        hold_b3 = 1'b0;

        run_query(7, 100, 1'b0, 1'b0, -1);
        run_query(5, 50, 1'b0, 1'b0, -1);
        run_query(3, 100, 1'b0, 1'b0, -1);
        run_query(1, 70, 1'b1, 1'b0, -1);

        ready_pct = 60;
        run_query(6, 80, 1'b1, 1'b0, 4);
        run_query(4, 70, 1'b0, 1'b0, -1);

        for (int q = 0; q < 8; q++) begin
            ready_pct = $urandom_range(30, 100);
            run_query($urandom_range(1, 12), $urandom_range(30, 100), 1'b1, 1'b0, -1);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #400000;
        flag("watchdog", "simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/knn_stream_ctrl.md
Name: knn_stream_ctrl

Overview:
Sequencer that feeds the KNN processing array: it loads one test vector, then streams train-dimension beats into the array's packed datain word.
- Tracks dimension and group counters and detects end of the train set.
- Captures the K-entry result burst emitted by the array and replays it downstream on a ready/valid stream.
- Sits between the DMA/stream front end and the KNN array inside the KNN_stream IP.

Parameters:
DIMS, 8, dimensions per vector (≥2)
KNNS, 3, train vectors compared per beat (array PE count)
K, 8, nearest neighbours returned per query
CNT_W, 32, width of train-vector count and group counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  pulse: begin query (accepted only in IDLE)
num_train  in  CNT_W  train vectors in set, sampled on accepted start
busy  out  1  high from accepted start until final result beat handshaked
err  out  1  one-cycle pulse: start accepted with num_train==0
s_valid  in  1  input stream valid
s_ready  out  1  input stream ready
s_data  in  32*KNNS  LOAD_TEST: bits[31:0]=test dim; STREAM: dim d of KNNS train vectors, MSW = lowest index
arr_en  out  1  array beat strobe
arr_datain  out  32*(KNNS+1)  {test_dim, train dims}; MSW = test dim
arr_done  in  1  array result-burst start indicator
arr_dataout  in  32  array result word (distance)
m_valid  out  1  result stream valid
m_ready  in  1  result stream ready
m_data  out  32  result distance, nearest first
m_last  out  1  high on the K-th result beat

Behaviour:
- Reset: state IDLE; busy, err, s_ready, arr_en, m_valid, m_last = 0; arr_datain, m_data = 0; all counters = 0. Reset mid-operation aborts immediately and returns to IDLE the next cycle; partial results are discarded.
- FSM states: IDLE, LOAD_TEST, STREAM, WAIT_RES, CAPTURE, OUTPUT.
- IDLE: on start with num_train>0, latch num_train, go to LOAD_TEST and set busy.
  - start with num_train==0: err pulses for 1 cycle, busy stays 0, no transition.
  - start outside IDLE is ignored.
- LOAD_TEST: s_ready=1. Each handshake writes s_data[31:0] into test_buf[dim_cnt]. After DIMS beats, dim_cnt wraps to 0 and the FSM goes to STREAM.
- STREAM: s_ready=1. arr_en is registered: on each handshake, next cycle arr_en=1 and arr_datain={test_buf[dim_cnt], s_data}. With no handshake, arr_en=0 and arr_datain holds its value.
  - After DIMS beats, dim_cnt wraps and sent += KNNS.
  - If sent ≥ num_train (compare in CNT_W+1 bits), go to WAIT_RES; otherwise continue.
  - The last group may be partial; upstream pads it, and the controller always consumes full beats.
- WAIT_RES: s_ready=0. On arr_done=1, capture arr_dataout into res_buf[0] in the same cycle and go to CAPTURE with res_cnt=1.
- CAPTURE: capture arr_dataout into res_buf[res_cnt] on each of the following K-1 consecutive cycles, with no gaps. After res_cnt reaches K, go to OUTPUT.
- OUTPUT: m_valid=1, m_data=res_buf[out_cnt], m_last=(out_cnt==K-1). out_cnt advances on m_valid&m_ready.
  - Handshake with m_last: next state IDLE, busy=0.
  - m_ready low holds m_data stable.
- arr_done outside WAIT_RES is ignored.
- Latency: accepted STREAM beat appears on arr_datain/arr_en exactly 1 cycle later. First m_valid appears 1 cycle after the K-th capture.
- Counters: dim_cnt ranges 0..DIMS-1; res_cnt and out_cnt range 0..K-1; sent saturates at 2^CNT_W-1.

Optional Feature:
KNN_CTRL_PERF_EN
- Defined: adds output perf_stall [31:0], counting STREAM cycles with s_valid=0. It clears on accepted start, saturates at all-ones, and resets to 0.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package knn_pkg:
  - state enum knn_ctrl_state_t.
  - WORD_W=32.
  - Helpers for beats-per-vector and groups-needed, ceil(num_train/KNNS).
- One sub-module: knn_result_buf. It is the K-entry capture RAM with write-pointer and read-pointer/handshake logic, and it drives m_valid/m_data/m_last.

Test Plan:
- Nominal (DIMS=8, KNNS=3, K=8, num_train=6):
  - 8 test beats then 16 train beats, s_valid always high → arr_en high for exactly 16 cycles, each 1 cycle after its handshake.
  - WAIT_RES then follows; arr_done+8 words 10..17 → m_data 10..17 in order, m_last on the 8th, busy falls after that handshake.
- num_train=7: 3 groups (24 train beats) consumed before WAIT_RES.
- num_train=0 start → err pulses 1 cycle, busy stays 0, s_ready stays 0.
- s_valid toggled 50% in STREAM → arr_en gaps match handshake gaps; arr_datain held during gaps; with KNN_CTRL_PERF_EN, perf_stall equals the gap count.
- m_ready low for 5 cycles on beat 3 → m_data stable at res_buf[3], no beat lost or duplicated.
- rst asserted mid-STREAM → next cycle IDLE with all outputs 0. A fresh query then completes correctly.
